// File: rtl/reaction_ctrl.sv
// Reaction-time game controller: random pre-stimulus delay, LED stimulus,
// then measures press latency in ms using an external up/down timer.
module reaction_ctrl #(
    parameter int MAX_MS       = 2047,
    parameter int MIN_DELAY_MS = 100,
    localparam int W           = $clog2(MAX_MS)
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_button_pressed,
    input  logic [W-1:0] i_rand_value,
    input  logic [W-1:0] i_timer_value,
    input  logic         i_max_reached,
    output logic         o_timer_reset,
    output logic         o_timer_up,
    output logic         o_timer_enable,
    output logic [W-1:0] o_timer_start_value,
    output logic         o_led_on,
    output logic [W-1:0] o_result_ms,
    output logic         o_result_valid,
    output logic         o_false_start,
    output logic         o_timeout,
    output logic [2:0]   o_state
);

    // state       | meaning
    // IDLE        | waiting for first press, timer held in load
    // ARM         | load countdown with random delay
    // DELAY       | counting down, LED off
    // ARM_UP      | clear timer for measurement, LED on
    // MEASURE     | counting up, waiting for press
    // DONE        | reaction time captured
    // FALSE_START | pressed before LED
    // TIMEOUT     | no press before full scale
    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        ARM         = 3'd1,
        DELAY       = 3'd2,
        ARM_UP      = 3'd3,
        MEASURE     = 3'd4,
        DONE        = 3'd5,
        FALSE_START = 3'd6,
        TIMEOUT     = 3'd7
    } state_t;

    localparam logic [W-1:0] MIN_D = W'(MIN_DELAY_MS);
    localparam logic [W-1:0] MAX_V = W'(MAX_MS);

    state_t       r_state;
    state_t       w_next;
    logic [W-1:0] r_delay;
    logic [W-1:0] r_result;
    logic [W-1:0] w_delay_next;
    logic [W-1:0] w_result_next;
    logic         w_latch_delay;
    logic         w_capture;

    // Floor keeps the countdown load non-zero and humanly fair.
    assign w_delay_next = (i_rand_value < MIN_D) ? MIN_D : i_rand_value;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state  <= IDLE;
            r_delay  <= MIN_D;
            r_result <= '0;
        end else begin
            r_state <= w_next;
            if (w_latch_delay) r_delay <= w_delay_next;
            if (w_capture)     r_result <= w_result_next;
        end
    end

    always_comb begin
        w_next         = r_state;
        w_latch_delay  = 1'b0;
        w_capture      = 1'b0;
        w_result_next  = r_result;
        o_timer_reset  = 1'b0;
        o_timer_up     = 1'b0;
        o_timer_enable = 1'b0;
        o_led_on       = 1'b0;
        o_result_valid = 1'b0;
        o_false_start  = 1'b0;
        o_timeout      = 1'b0;
        case (r_state)
            IDLE: begin
                o_timer_reset = 1'b1;
                if (i_button_pressed) begin
                    w_next        = ARM;
                    w_latch_delay = 1'b1;
                end
            end
            ARM: begin
                o_timer_reset = 1'b1;
                w_next        = DELAY;
            end
            DELAY: begin
                o_timer_enable = 1'b1;
                if (i_button_pressed)          w_next = FALSE_START;
                else if (i_timer_value == '0)  w_next = ARM_UP;
            end
            ARM_UP: begin
                o_timer_reset = 1'b1;
                o_timer_up    = 1'b1;
                o_led_on      = 1'b1;
                if (i_button_pressed) begin
                    w_next        = DONE;
                    w_capture     = 1'b1;
                    w_result_next = '0;
                end else begin
                    w_next = MEASURE;
                end
            end
            MEASURE: begin
                o_timer_enable = 1'b1;
                o_timer_up     = 1'b1;
                o_led_on       = 1'b1;
                if (i_button_pressed) begin
                    w_next        = DONE;
                    w_capture     = 1'b1;
                    w_result_next = i_timer_value;
                end else if (i_max_reached) begin
                    w_next        = TIMEOUT;
                    w_capture     = 1'b1;
                    w_result_next = MAX_V;
                end
            end
            DONE, FALSE_START, TIMEOUT: begin
                o_result_valid = (r_state == DONE);
                o_false_start  = (r_state == FALSE_START);
                o_timeout      = (r_state == TIMEOUT);
                if (i_button_pressed) begin
                    w_next        = ARM;
                    w_latch_delay = 1'b1;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    assign o_timer_start_value = r_delay;
    assign o_result_ms         = r_result;
    assign o_state             = r_state;

endmodule

// File: tb/tb_reaction_ctrl.sv
// Directed bench for reaction_ctrl with a behavioural ms timer (4 clocks per ms).
module tb_reaction_ctrl;

    localparam int MAX = 2047;
    localparam int W   = 11;
    localparam int CPM = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         btn = 1'b0;
    logic [W-1:0] rand_value = '0;
    logic [W-1:0] t_cnt = '0;
    logic [1:0]   t_pre = '0;
    logic         max_reached;
    logic         timer_reset, timer_up, timer_enable, led_on;
    logic         result_valid, false_start, timeout;
    logic [W-1:0] start_value, result_ms;
    logic [2:0]   state;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    reaction_ctrl #(.MAX_MS(MAX), .MIN_DELAY_MS(100)) dut (
        .i_clk               (clk),
        .i_reset             (reset),
        .i_button_pressed    (btn),
        .i_rand_value        (rand_value),
        .i_timer_value       (t_cnt),
        .i_max_reached       (max_reached),
        .o_timer_reset       (timer_reset),
        .o_timer_up          (timer_up),
        .o_timer_enable      (timer_enable),
        .o_timer_start_value (start_value),
        .o_led_on            (led_on),
        .o_result_ms         (result_ms),
        .o_result_valid      (result_valid),
        .o_false_start       (false_start),
        .o_timeout           (timeout),
        .o_state             (state)
    );

    // Saturating up/down ms timer with synchronous load.
    always @(posedge clk) begin
        if (timer_reset) begin
            t_cnt <= timer_up ? '0 : start_value;
            t_pre <= '0;
        end else if (timer_enable) begin
            if (t_pre == 2'(CPM - 1)) begin
                t_pre <= '0;
                if (timer_up) begin
                    if (t_cnt != W'(MAX)) t_cnt <= t_cnt + 1'b1;
                end else if (t_cnt != '0) begin
                    t_cnt <= t_cnt - 1'b1;
                end
            end else begin
                t_pre <= t_pre + 1'b1;
            end
        end
    end
    assign max_reached = (t_cnt == W'(MAX));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press();
        btn = 1'b1;
        tick();
        btn = 1'b0;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Ticks until LED rises; ARM + 4*d + 2 edges from the press.
    task automatic led_latency(input string tag, input int exp);
        int n = 0;
        while (!led_on && n < 20000) begin
            tick();
            n++;
        end
        check(tag, 32'(n), 32'(exp));
    endtask

    task automatic wait_timer(input string tag, input int val);
        int n = 0;
        while (t_cnt != W'(val) && n < 12000) begin
            tick();
            n++;
        end
        check(tag, 32'(t_cnt), 32'(val));
    endtask

    initial begin
        // Reset
        reset = 1'b1;
        repeat (3) tick();
        check("rst_state", 32'(state), 0);
        check("rst_led", 32'(led_on), 0);
        check("rst_result", 32'(result_ms), 0);
        check("rst_treset", 32'(timer_reset), 1);
        check("rst_flags", {29'd0, result_valid, false_start, timeout}, 0);
        check("rst_enable", 32'(timer_enable), 0);
        reset = 1'b0;
        tick();

        // Round A: 300 ms delay, press at 57 ms
        rand_value = 11'd300;
        press();
        check("a_arm", 32'(state), 1);
        check("a_start", 32'(start_value), 300);
        led_latency("a_led_lat", 4 * 300 + 2);
        check("a_armup", 32'(state), 3);
        wait_timer("a_t57", 57);
        check("a_measure", 32'(state), 4);
        press();
        check("a_done", 32'(state), 5);
        check("a_result", 32'(result_ms), 57);
        check("a_valid", 32'(result_valid), 1);
        check("a_led_off", 32'(led_on), 0);

        // Round B: rand below floor -> 100 ms, press at 9 ms
        rand_value = 11'd20;
        press();
        check("b_start", 32'(start_value), 100);
        led_latency("b_led_lat", 4 * 100 + 2);
        wait_timer("b_t9", 9);
        press();
        check("b_result", 32'(result_ms), 9);

        // Round C: false start 200 ms into DELAY; press in ARM ignored
        rand_value = 11'd500;
        press();
        check("c_arm", 32'(state), 1);
        press();
        check("c_arm_ignore", 32'(state), 2);
        wait_timer("c_t300", 300);
        press();
        check("c_fs_state", 32'(state), 6);
        check("c_fs_flag", 32'(false_start), 1);
        check("c_fs_led", 32'(led_on), 0);
        check("c_fs_enable", 32'(timer_enable), 0);
        check("c_fs_result", 32'(result_ms), 9);
        check("c_fs_valid", 32'(result_valid), 0);

        // Round D: timeout at full scale
        rand_value = 11'd150;
        press();
        led_latency("d_led_lat", 4 * 150 + 2);
        wait_timer("d_tmax", MAX);
        check("d_pre_to", 32'(state), 4);
        tick();
        check("d_to_state", 32'(state), 7);
        check("d_to_result", 32'(result_ms), MAX);
        check("d_to_flag", 32'(timeout), 1);
        check("d_to_led", 32'(led_on), 0);

        // Round E: new round from TIMEOUT, rand 0 -> floor, press in ARM_UP
        rand_value = 11'd0;
        press();
        check("e_arm", 32'(state), 1);
        check("e_start", 32'(start_value), 100);
        led_latency("e_led_lat", 4 * 100 + 2);
        check("e_armup", 32'(state), 3);
        press();
        check("e_state", 32'(state), 5);
        check("e_result", 32'(result_ms), 0);

        // Round F: press coincident with max_reached -> DONE
        rand_value = 11'd100;
        press();
        led_latency("f_led_lat", 4 * 100 + 2);
        wait_timer("f_tmax", MAX);
        check("f_maxflag", 32'(max_reached), 1);
        press();
        check("f_state", 32'(state), 5);
        check("f_result", 32'(result_ms), MAX);
        check("f_timeout", 32'(timeout), 0);

        // Round G: reset mid-MEASURE
        rand_value = 11'd120;
        press();
        led_latency("g_led_lat", 4 * 120 + 2);
        repeat (10) tick();
        check("g_measure", 32'(state), 4);
        reset = 1'b1;
        tick();
        check("g_rst_state", 32'(state), 0);
        check("g_rst_led", 32'(led_on), 0);
        check("g_rst_result", 32'(result_ms), 0);
        check("g_rst_flags", {29'd0, result_valid, false_start, timeout}, 0);
        check("g_rst_start", 32'(start_value), 100);
        reset = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/reaction_ctrl.md
REACTION_CTRL -- requirements
Module: reaction_ctrl

Interface
REQ-001 Parameter MAX_MS, default 2047, full-scale ms count; W = $clog2(MAX_MS) bits for all ms values.
REQ-002 Parameter MIN_DELAY_MS, default 100, floor on random pre-stimulus delay; 1 <= MIN_DELAY_MS < MAX_MS.
REQ-003 clk  input  1  single system clock, all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 button_pressed  input  1  debounced single-cycle press pulse.
REQ-006 rand_value  input  W  free-running random delay source, ms.
REQ-007 timer_value  input  W  current ms count from the downstream timer.
REQ-008 max_reached  input  1  timer full-scale flag.
REQ-009 timer_reset  output  1  synchronous reset/load strobe to the timer.
REQ-010 timer_up  output  1  timer direction, 1 = count up.
REQ-011 timer_enable  output  1  timer count enable.
REQ-012 timer_start_value  output  W  countdown load value.
REQ-013 led_on  output  1  stimulus LED.
REQ-014 result_ms  output  W  captured reaction time.
REQ-015 result_valid, false_start, timeout  output  1 each  round outcome flags, held while in the matching state.
REQ-016 state  output  3  current state encoding, debug.

Function
REQ-017 States: IDLE=0, ARM=1, DELAY=2, ARM_UP=3, MEASURE=4, DONE=5, FALSE_START=6, TIMEOUT=7.
REQ-018 timer_reset, timer_up, timer_enable, led_on, result_valid, false_start and timeout are Moore decodes of the state register, with no added latency.
REQ-019 IDLE: timer_enable=0, led_on=0; button_pressed -> ARM; delay_reg <= max(rand_value, MIN_DELAY_MS), sampled on the press cycle.
REQ-020 ARM (1 cycle): timer_reset=1, timer_up=0, timer_start_value=delay_reg; -> DELAY unconditionally.
REQ-021 DELAY: timer_enable=1, timer_up=0, led_on=0; button_pressed -> FALSE_START; else timer_value==0 -> ARM_UP; button has priority.
REQ-022 ARM_UP (1 cycle): timer_reset=1, timer_up=1, led_on=1; button_pressed -> DONE with result_ms <= 0; else -> MEASURE.
REQ-023 MEASURE: timer_enable=1, timer_up=1, led_on=1; button_pressed -> DONE, result_ms <= timer_value; else max_reached -> TIMEOUT, result_ms <= MAX_MS; simultaneous press and max_reached -> DONE.
REQ-024 DONE: result_valid=1; FALSE_START: false_start=1; TIMEOUT: timeout=1; in all three, timer_enable=0, led_on=0, result_ms held.
REQ-025 button_pressed in DONE, FALSE_START or TIMEOUT starts a new round -> ARM, re-latching delay_reg exactly as in REQ-019; result_ms holds until the next capture.
REQ-026 timer_start_value always equals delay_reg; delay_reg is W bits and is never zero.
REQ-027 button_pressed in ARM is ignored.

Reset
REQ-028 While reset=1: state <= IDLE; result_ms <= 0; delay_reg <= MIN_DELAY_MS; timer_reset=1; timer_up=0; timer_enable=0; led_on=0; all outcome flags 0.
REQ-029 Reset mid-round (any state) aborts the round within one cycle with no outcome flag asserted.

Verification (bench instantiates the timer with CLKS_PER_MS=4, MAX_MS=2047)
REQ-030 Assert reset for 3 cycles -> state=0, led_on=0, result_ms=0, timer_reset=1, all flags 0.
REQ-031 rand_value=300, press in IDLE; after 300 ms led_on=1; press at timer_value=57 -> DONE, result_ms=57, result_valid=1.
REQ-032 rand_value=20, press -> timer_start_value=100, led_on rises 100 ms after ARM.
REQ-033 rand_value=500, press again 200 ms into DELAY -> false_start=1, led_on=0, timer_enable=0, result_ms unchanged.
REQ-034 No press in MEASURE -> max_reached -> TIMEOUT, result_ms=2047, timeout=1; then a press -> ARM.
REQ-035 Press coincident with max_reached in MEASURE -> DONE, result_ms=timer_value; reset asserted in MEASURE -> IDLE next cycle, led_on=0.
